// File: rtl/logic_unit_if.sv
// Operand/result handshake bundle for logic_unit_pipe: valid/ready request
// side carrying op and operands, valid/ready response side carrying result and flags.
interface logic_unit_if #(
  parameter int WIDTH = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       op;
  logic             acc_sel;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             parity;
  logic             all_ones;

  modport master (
    output in_valid, op, acc_sel, a, b, out_ready,
    input  in_ready, out_valid, result, zero, parity, all_ones
  );

  modport slave (
    input  in_valid, op, acc_sel, a, b, out_ready,
    output in_ready, out_valid, result, zero, parity, all_ones
  );
endinterface

// File: rtl/logic_unit_pipe.sv
// Registered WIDTH-bit eight-function logic unit with a 1-entry output register,
// result-chaining accumulator, result flags and a saturating accepted-op counter.
module logic_unit_pipe #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_acc,
  output logic [CNT_W-1:0] op_count,
  logic_unit_if.slave      bus
);

  typedef enum logic [2:0] {
    OP_NOT  = 3'b000,
    OP_OR   = 3'b001,
    OP_AND  = 3'b010,
    OP_XOR  = 3'b011,
    OP_NAND = 3'b100,
    OP_NOR  = 3'b101,
    OP_XNOR = 3'b110,
    OP_PASS = 3'b111
  } op_e;

  function automatic logic [WIDTH-1:0] logic_op(
    input logic [2:0]       op,
    input logic [WIDTH-1:0] a,
    input logic [WIDTH-1:0] bsrc
  );
    logic [WIDTH-1:0] r;
    case (op_e'(op))
      OP_NOT:  r = ~a;
      OP_OR:   r = a | bsrc;
      OP_AND:  r = a & bsrc;
      OP_XOR:  r = a ^ bsrc;
      OP_NAND: r = ~(a & bsrc);
      OP_NOR:  r = ~(a | bsrc);
      OP_XNOR: r = ~(a ^ bsrc);
      default: r = a;
    endcase
    return r;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + CNT_W'(1);
  endfunction

  logic             accept;
  logic             xfer;
  logic [WIDTH-1:0] bsrc_p0;
  logic [WIDTH-1:0] res_p0;

  logic [WIDTH-1:0] res_p1_q,  res_p1_d;
  logic             vld_p1_q,  vld_p1_d;
  logic             zero_p1_q, zero_p1_d;
  logic             par_p1_q,  par_p1_d;
  logic             ones_p1_q, ones_p1_d;
  logic [WIDTH-1:0] acc_q,     acc_d;
  logic [CNT_W-1:0] cnt_q,     cnt_d;

  // ---- stage p0: operand select and compute ----
  assign bus.in_ready = !vld_p1_q || bus.out_ready;
  assign accept       = bus.in_valid && bus.in_ready;
  assign xfer         = vld_p1_q && bus.out_ready;
  assign bsrc_p0      = bus.acc_sel ? acc_q : bus.b;
  assign res_p0       = logic_op(bus.op, bus.a, bsrc_p0);

  always_comb begin
    res_p1_d  = res_p1_q;
    vld_p1_d  = vld_p1_q;
    zero_p1_d = zero_p1_q;
    par_p1_d  = par_p1_q;
    ones_p1_d = ones_p1_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    if (accept) begin
      res_p1_d  = res_p0;
      vld_p1_d  = 1'b1;
      zero_p1_d = (res_p0 == '0);
      par_p1_d  = ^res_p0;
      ones_p1_d = &res_p0;
      acc_d     = res_p0;
      cnt_d     = sat_inc(cnt_q);
    end else if (xfer) begin
      vld_p1_d  = 1'b0;
    end
    // Clear wins over the accept's update; the accept already read the old acc.
    if (clr_acc) begin
      acc_d = '0;
      cnt_d = '0;
    end
  end

  // ---- stage p1: output register, accumulator, counter ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_p1_q  <= '0;
      vld_p1_q  <= 1'b0;
      zero_p1_q <= 1'b0;
      par_p1_q  <= 1'b0;
      ones_p1_q <= 1'b0;
      acc_q     <= '0;
      cnt_q     <= '0;
    end else begin
      res_p1_q  <= res_p1_d;
      vld_p1_q  <= vld_p1_d;
      zero_p1_q <= zero_p1_d;
      par_p1_q  <= par_p1_d;
      ones_p1_q <= ones_p1_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
    end
  end

  assign bus.out_valid = vld_p1_q;
  assign bus.result    = res_p1_q;
  assign bus.zero      = zero_p1_q;
  assign bus.parity    = par_p1_q;
  assign bus.all_ones  = ones_p1_q;
  assign op_count      = cnt_q;

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Directed bench for logic_unit_pipe: ops, flags, backpressure, chaining,
// clear/accept collision, counter saturation and asynchronous reset.
module tb_logic_unit_pipe;

  logic       clk;
  logic       rst_n;
  logic       rst2_n;
  logic       clr1;
  logic       clr2;
  logic [7:0] cnt1;
  logic [1:0] cnt2;
  int         n_chk;
  int         n_bad;

  logic_unit_if #(.WIDTH(4)) bus1 ();
  logic_unit_if #(.WIDTH(4)) bus2 ();

  logic_unit_pipe #(.WIDTH(4), .CNT_W(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr_acc  (clr1),
    .op_count (cnt1),
    .bus      (bus1)
  );

  logic_unit_pipe #(.WIDTH(4), .CNT_W(2)) dut2 (
    .clk      (clk),
    .rst_n    (rst2_n),
    .clr_acc  (clr2),
    .op_count (cnt2),
    .bus      (bus2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drv1(input logic v, input logic [2:0] op, input logic [3:0] a,
                      input logic [3:0] b, input logic sel);
    bus1.in_valid = v;
    bus1.op       = op;
    bus1.a        = a;
    bus1.b        = b;
    bus1.acc_sel  = sel;
  endtask

  initial begin
    n_chk = 0;
    n_bad = 0;
    rst_n = 1'b0;
    rst2_n = 1'b0;
    clr1 = 1'b0;
    clr2 = 1'b0;
    drv1(1'b0, 3'b000, 4'h0, 4'h0, 1'b0);
    bus1.out_ready = 1'b0;
    bus2.in_valid = 1'b0;
    bus2.op = 3'b111;
    bus2.a = 4'h0;
    bus2.b = 4'h0;
    bus2.acc_sel = 1'b0;
    bus2.out_ready = 1'b1;
    repeat (2) tick();

    chk("rst_valid", bus1.out_valid, 0);
    chk("rst_result", bus1.result, 0);
    chk("rst_flags", {bus1.zero, bus1.parity, bus1.all_ones}, 0);
    chk("rst_count", cnt1, 0);
    rst_n = 1'b1;
    rst2_n = 1'b1;
    tick();
    chk("rst_in_ready", bus1.in_ready, 1);

    // Legacy ops
    bus1.out_ready = 1'b1;
    drv1(1'b1, 3'b001, 4'b1100, 4'b1010, 1'b0);
    tick();
    chk("or_valid", bus1.out_valid, 1);
    chk("or", bus1.result, 4'b1110);
    chk("or_parity", bus1.parity, 1);
    drv1(1'b1, 3'b010, 4'b1100, 4'b1010, 1'b0);
    tick();
    chk("and", bus1.result, 4'b1000);
    drv1(1'b1, 3'b011, 4'b1100, 4'b1010, 1'b0);
    tick();
    chk("xor", bus1.result, 4'b0110);
    chk("xor_parity", bus1.parity, 0);
    drv1(1'b1, 3'b000, 4'b1100, 4'b1010, 1'b0);
    tick();
    chk("not", bus1.result, 4'b0011);
    chk("count4", cnt1, 4);

    // Extended ops
    drv1(1'b1, 3'b100, 4'b1100, 4'b1010, 1'b0);
    tick();
    chk("nand", bus1.result, 4'b0111);
    drv1(1'b1, 3'b101, 4'b1100, 4'b1010, 1'b0);
    tick();
    chk("nor", bus1.result, 4'b0001);
    drv1(1'b1, 3'b110, 4'b1100, 4'b1010, 1'b0);
    tick();
    chk("xnor", bus1.result, 4'b1001);
    drv1(1'b1, 3'b111, 4'b1100, 4'b1010, 1'b0);
    tick();
    chk("pass", bus1.result, 4'b1100);
    drv1(1'b1, 3'b011, 4'b0101, 4'b0101, 1'b0);
    tick();
    chk("xor_eq", bus1.result, 4'b0000);
    chk("xor_eq_flags", {bus1.zero, bus1.parity, bus1.all_ones}, 3'b100);
    drv1(1'b1, 3'b110, 4'b0101, 4'b0101, 1'b0);
    tick();
    chk("xnor_eq", bus1.result, 4'b1111);
    chk("xnor_eq_flags", {bus1.zero, bus1.parity, bus1.all_ones}, 3'b001);
    chk("count10", cnt1, 10);

    // Backpressure
    drv1(1'b0, 3'b000, 4'h0, 4'h0, 1'b0);
    tick();
    chk("drain_valid", bus1.out_valid, 0);
    bus1.out_ready = 1'b0;
    drv1(1'b1, 3'b111, 4'b0101, 4'h0, 1'b0);
    tick();
    chk("bp_result", bus1.result, 4'b0101);
    drv1(1'b1, 3'b111, 4'b1111, 4'h0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_in_ready", bus1.in_ready, 0);
      chk("bp_hold", bus1.result, 4'b0101);
      chk("bp_valid", bus1.out_valid, 1);
      chk("bp_count", cnt1, 11);
    end
    drv1(1'b0, 3'b111, 4'b1111, 4'h0, 1'b0);
    bus1.out_ready = 1'b1;
    #1;
    chk("release_in_ready", bus1.in_ready, 1);
    tick();
    chk("release_xfer", bus1.out_valid, 0);
    drv1(1'b1, 3'b111, 4'b0011, 4'h0, 1'b0);
    tick();
    chk("post_bp", bus1.result, 4'b0011);
    chk("count12", cnt1, 12);

    // Chaining through the accumulator
    drv1(1'b1, 3'b111, 4'b0001, 4'h0, 1'b0);
    tick();
    chk("chain0", bus1.result, 4'b0001);
    drv1(1'b1, 3'b011, 4'b0011, 4'hF, 1'b1);
    tick();
    chk("chain1", bus1.result, 4'b0010);
    drv1(1'b1, 3'b011, 4'b0101, 4'hF, 1'b1);
    tick();
    chk("chain2", bus1.result, 4'b0111);

    // Clear colliding with accept
    drv1(1'b1, 3'b111, 4'b0110, 4'h0, 1'b0);
    tick();
    chk("acc_load", bus1.result, 4'b0110);
    chk("count16", cnt1, 16);
    clr1 = 1'b1;
    drv1(1'b1, 3'b001, 4'b0000, 4'hF, 1'b1);
    tick();
    clr1 = 1'b0;
    chk("clr_result", bus1.result, 4'b0110);
    chk("clr_count", cnt1, 0);
    drv1(1'b1, 3'b001, 4'b0000, 4'hF, 1'b1);
    tick();
    chk("clr_acc_zero", bus1.result, 4'b0000);
    chk("clr_zero_flag", bus1.zero, 1);
    chk("clr_count1", cnt1, 1);
    drv1(1'b0, 3'b000, 4'h0, 4'h0, 1'b0);

    // Saturating counter, CNT_W=2
    for (int i = 0; i < 5; i++) begin
      bus2.in_valid = 1'b1;
      bus2.a = 4'(i + 1);
      tick();
      chk("sat_count", cnt2, (i < 3) ? i + 1 : 3);
    end
    bus2.in_valid = 1'b0;
    chk("sat_result", bus2.result, 4'd5);
    chk("sat_valid", bus2.out_valid, 1);

    // Asynchronous reset mid-stream
    bus2.out_ready = 1'b0;
    #2;
    rst2_n = 1'b0;
    #1;
    chk("arst_valid", bus2.out_valid, 0);
    chk("arst_result", bus2.result, 0);
    chk("arst_count", cnt2, 0);
    chk("arst_flags", {bus2.zero, bus2.parity, bus2.all_ones}, 0);
    tick();
    rst2_n = 1'b1;
    tick();
    chk("arst_in_ready", bus2.in_ready, 1);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
